// File: rtl/de2i_150_qsys_timer_sched.sv
// One-shot delay scheduler that shares a single Avalon-MM interval timer
// among N_REQ requesters. Requests are granted round-robin; for each grant the
// timer period is programmed, the timer is started in one-shot mode with its
// interrupt enabled, and the owner gets a done pulse after the irq is cleared.
// Optional build macro: TIMER_SCHED_CANCEL_EN adds a per-requester cancel input.
module de2i_150_qsys_timer_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] req_delay,
`ifdef TIMER_SCHED_CANCEL_EN
  input  logic [N_REQ-1:0]    cancel,
`endif
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [ID_W-1:0]     active_id,
  output logic [2:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [15:0]         avm_writedata,
  input  logic                timer_irq
);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StZchk  = 4'd1;
  localparam logic [3:0] StWrPl  = 4'd2;
  localparam logic [3:0] StWrPh  = 4'd3;
  localparam logic [3:0] StGap   = 4'd4;
  localparam logic [3:0] StWrCtl = 4'd5;
  localparam logic [3:0] StWait  = 4'd6;
  localparam logic [3:0] StClr   = 4'd7;
  localparam logic [3:0] StClr2  = 4'd8;
  localparam logic [3:0] StDone  = 4'd9;
  localparam logic [3:0] StStop  = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]      delay_q, delay_d;
  logic [31:0]      period;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [ID_W-1:0]  next_id;

  logic [N_REQ-1:0] done_d;
  logic             busy_d;
  logic [2:0]       addr_d;
  logic             cs_d;
  logic             wn_d;
  logic [15:0]      wdata_d;

`ifdef TIMER_SCHED_CANCEL_EN
  logic             cancelled_q, cancelled_d;
`endif

  assign period    = delay_q - 32'd1;
  assign next_id   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
  assign active_id = id_q;

  // Round-robin pick: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_w;
    idx         = 0;
    idx_w       = '0;
    grant_id    = rr_ptr_q;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx   = (32'(rr_ptr_q) + k) % N_REQ;
      idx_w = ID_W'(idx);
      if (!grant_found && req[idx_w]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  // Next-state logic for the sequencer, owner id, latched delay and rr pointer.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    delay_d  = delay_q;
    rr_ptr_d = rr_ptr_q;
`ifdef TIMER_SCHED_CANCEL_EN
    cancelled_d = cancelled_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef TIMER_SCHED_CANCEL_EN
        cancelled_d = 1'b0;
`endif
        if (grant_found) begin
          id_d    = grant_id;
          delay_d = req_delay[32*int'(grant_id) +: 32];
          state_d = StZchk;
        end
      end
      StZchk:  state_d = (delay_q == 32'd0) ? StDone : StWrPl;
      StWrPl:  state_d = StWrPh;
      StWrPh:  state_d = StGap;
      StGap:   state_d = StWrCtl;
      StWrCtl: state_d = StWait;
      StWait: begin
`ifdef TIMER_SCHED_CANCEL_EN
        if (cancel[id_q]) begin
          cancelled_d = 1'b1;
          state_d     = StStop;
        end else if (timer_irq) begin
          state_d = StClr;
        end
`else
        if (timer_irq) state_d = StClr;
`endif
      end
      StStop: state_d = StClr;
      StClr:  state_d = StClr2;
      StClr2: begin
`ifdef TIMER_SCHED_CANCEL_EN
        if (cancelled_q) begin
          rr_ptr_d = next_id;
          state_d  = StIdle;
        end else begin
          state_d = StDone;
        end
`else
        state_d = StDone;
`endif
      end
      StDone: begin
        rr_ptr_d = next_id;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output is registered yet
  // lines up with the state it belongs to.
  always_comb begin
    done_d  = '0;
    busy_d  = (state_d != StIdle);
    addr_d  = 3'd0;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    wdata_d = 16'h0000;
    case (state_d)
      StWrPl: begin
        addr_d = 3'd2; cs_d = 1'b1; wn_d = 1'b0; wdata_d = period[15:0];
      end
      StWrPh: begin
        addr_d = 3'd3; cs_d = 1'b1; wn_d = 1'b0; wdata_d = period[31:16];
      end
      StWrCtl: begin
        addr_d = 3'd1; cs_d = 1'b1; wn_d = 1'b0; wdata_d = 16'h0005;
      end
      StStop: begin
        addr_d = 3'd1; cs_d = 1'b1; wn_d = 1'b0; wdata_d = 16'h0008;
      end
      StClr: begin
        addr_d = 3'd0; cs_d = 1'b1; wn_d = 1'b0; wdata_d = 16'h0000;
      end
      StClr2: begin
        addr_d = 3'd1; cs_d = 1'b1; wn_d = 1'b0; wdata_d = 16'h0000;
      end
      StDone: done_d[id_d] = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      id_q           <= '0;
      rr_ptr_q       <= '0;
      delay_q        <= 32'd0;
      done           <= '0;
      busy           <= 1'b0;
      avm_address    <= 3'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      rr_ptr_q       <= rr_ptr_d;
      delay_q        <= delay_d;
      done           <= done_d;
      busy           <= busy_d;
      avm_address    <= addr_d;
      avm_chipselect <= cs_d;
      avm_write_n    <= wn_d;
      avm_writedata  <= wdata_d;
    end
  end

`ifdef TIMER_SCHED_CANCEL_EN
  // Remembers that the current owner cancelled, so CLR2 skips the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cancelled_q <= 1'b0;
    else          cancelled_q <= cancelled_d;
  end
`endif

endmodule

// File: tb/tb_de2i_150_qsys_timer_sched.sv
// Bench for de2i_150_qsys_timer_sched: behavioural interval timer, table of
// request vectors, randomized request mixes against a round-robin model, and
// hand sequences for stray irq, reset during WAIT and (optionally) cancel.
module tb_de2i_150_qsys_timer_sched;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_delay = '0;
  logic [3:0]   done;
  logic         busy;
  logic [1:0]   active_id;
  logic [2:0]   avm_address;
  logic         avm_chipselect;
  logic         avm_write_n;
  logic [15:0]  avm_writedata;
  logic         timer_irq;
  logic         stray = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
  logic [3:0]   cancel = '0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ptr_m = 0;
  int wq_a[$];
  int wq_d[$];

  de2i_150_qsys_timer_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_delay      (req_delay),
`ifdef TIMER_SCHED_CANCEL_EN
    .cancel         (cancel),
`endif
    .done           (done),
    .busy           (busy),
    .active_id      (active_id),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .timer_irq      (timer_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: irq becomes visible D = period+1 cycles after the
  // cycle carrying the start write.
  logic [31:0] t_period, t_cnt;
  logic        t_run, t_to, t_ito;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
        else t_cnt <= t_cnt - 1;
      end
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= avm_writedata[0];
            if (avm_writedata[2]) begin
              if (t_period == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
              else begin t_cnt <= t_period - 1; t_run <= 1'b1; end
            end
            if (avm_writedata[3]) t_run <= 1'b0;
          end
          3'd2: t_period[15:0] <= avm_writedata;
          3'd3: t_period[31:16] <= avm_writedata;
          default: ;
        endcase
      end
    end
  end
  assign timer_irq = (t_to & t_ito) | stray;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Samples until a done pulse, logging bus writes and key cycle stamps.
  task automatic wait_done(input int limit, output int id, output bit ok, output int pl_c,
                           output int ctl_c, output int busy_c, output int done_c);
    wq_a.delete(); wq_d.delete();
    id = -1; ok = 1'b0; pl_c = -1; ctl_c = -1; busy_c = -1; done_c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy && busy_c < 0) busy_c = cyc;
      if (avm_chipselect && !avm_write_n) begin
        wq_a.push_back(int'(avm_address)); wq_d.push_back(int'(avm_writedata));
        if (avm_address == 3'd2 && pl_c < 0) pl_c = cyc;
        if (avm_address == 3'd1 && avm_writedata == 16'h0005) ctl_c = cyc;
      end
      if (done != '0) begin
        chk("done_onehot", $countones(done), 1);
        for (int b = 0; b < 4; b++) if (done[b]) id = b;
        done_c = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_one(input int exp_id, input logic [31:0] d, input int id, input bit ok,
                           input int pl_c, input int ctl_c, input int busy_c, input int done_c);
    logic [31:0] p;
    int ea[5];
    int ed[5];
    chk("done_seen", ok, 1);
    if (!ok) return;
    chk("done_id", id, exp_id);
    if (d == 0) begin
      chk("zero_writes", wq_a.size(), 0);
      chk("zero_latency", done_c - busy_c, 1);
    end else begin
      p  = d - 32'd1;
      ea = '{2, 3, 1, 0, 1};
      ed = '{int'(p[15:0]), int'(p[31:16]), 5, 0, 0};
      chk("n_writes", wq_a.size(), 5);
      for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
        chk("wr_addr", wq_a[i], ea[i]);
        chk("wr_data", wq_d[i], ed[i]);
      end
      chk("grant_to_pl", pl_c - busy_c, 1);
      chk("pl_to_start", ctl_c - pl_c, 3);
      chk("start_to_done", done_c - ctl_c, longint'(d) + 3);
    end
  endtask

  // Drives a request mix and checks each completion in the expected order.
  task automatic serve(input logic [3:0] mask, input logic [127:0] dl, input int ord[$]);
    int id, pl_c, ctl_c, busy_c, done_c;
    bit ok;
    logic [31:0] d;
    req = mask; req_delay = dl;
    foreach (ord[j]) begin
      d = dl[32*ord[j] +: 32];
      wait_done(int'(d) + 100, id, ok, pl_c, ctl_c, busy_c, done_c);
      check_one(ord[j], d, id, ok, pl_c, ctl_c, busy_c, done_c);
      if (!ok) begin req = '0; return; end
      req[id] = 1'b0;
    end
    if (ord.size() > 0) ptr_m = (ord[ord.size()-1] + 1) % 4;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] delay;
    int          n;
    int          ord[4];
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   ord[$];
    logic [3:0] m;
    logic [127:0] dl;
    int id, pl_c, ctl_c, busy_c, done_c;
    bit ok;

    tbl[0] = '{4'b1111, 32'd10,        4, '{0, 1, 2, 3}};
    tbl[1] = '{4'b0010, 32'd100,       1, '{1, 0, 0, 0}};
    tbl[2] = '{4'b0100, 32'd0,         1, '{2, 0, 0, 0}};
    tbl[3] = '{4'b0001, 32'd1,         1, '{0, 0, 0, 0}};
    tbl[4] = '{4'b1000, 32'h0001_0000, 1, '{3, 0, 0, 0}};
    tbl[5] = '{4'b0101, 32'd5,         2, '{0, 2, 0, 0}};
    tbl[6] = '{4'b0110, 32'd3,         2, '{1, 2, 0, 0}};

    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write_n", avm_write_n, 1);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[v]) begin
      ord.delete();
      for (int j = 0; j < tbl[v].n; j++) ord.push_back(tbl[v].ord[j]);
      serve(tbl[v].mask, {4{tbl[v].delay}}, ord);
    end

    for (int it = 0; it < 25; it++) begin
      int p;
      m = 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) dl[32*b +: 32] = 32'($urandom_range(0, 40));
      ord.delete();
      p = ptr_m;
      for (logic [3:0] rem = m; rem != 0; ) begin
        int g;
        g = pick(rem, p);
        ord.push_back(g);
        rem[g] = 1'b0;
        p = (g + 1) % 4;
      end
      serve(m, dl, ord);
    end

    // Stray irq while idle must not start anything.
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_cs", avm_chipselect, 0);
    end
    stray = 1'b0;
    @(negedge clk);

    // Reset during WAIT, then the still-held request is granted again.
    req = 4'b0100; req_delay = {4{32'd200}};
    repeat (20) @(negedge clk);
    chk("wait_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_active_id", active_id, 0);
    chk("mid_rst_cs", avm_chipselect, 0);
    chk("mid_rst_write_n", avm_write_n, 1);
    chk("mid_rst_done", done, 0);
    ptr_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    ord.delete(); ord.push_back(pick(req, ptr_m));
    serve(req, req_delay, ord);

`ifdef TIMER_SCHED_CANCEL_EN
    // Cancel 20 cycles into WAIT: STOP, CLR, CLR2, no done, next owner served.
    req = 4'b0011; req_delay = {32'd0, 32'd0, 32'd5, 32'd100};
    repeat (26) @(negedge clk);
    cancel = 4'b0001;
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin cancel = '0; req[0] = 1'b0; end
      chk("cancel_no_done", done, 0);
      if (avm_chipselect && !avm_write_n) begin
        wq_a.push_back(int'(avm_address)); wq_d.push_back(int'(avm_writedata));
      end
    end
    chk("cancel_n_writes", wq_a.size(), 3);
    if (wq_a.size() == 3) begin
      chk("stop_addr", wq_a[0], 1); chk("stop_data", wq_d[0], 8);
      chk("clr_addr", wq_a[1], 0);  chk("clr_data", wq_d[1], 0);
      chk("clr2_addr", wq_a[2], 1); chk("clr2_data", wq_d[2], 0);
    end
    wait_done(200, id, ok, pl_c, ctl_c, busy_c, done_c);
    check_one(1, 32'd5, id, ok, pl_c, ctl_c, busy_c, done_c);
    req = '0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
